// File: rtl/game_pkg.sv
// Shared definitions for the sprite movers: motion states, screen geometry
// and the frame-rate divider constant.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RIGHT,
    ST_DROP_L,
    ST_LEFT,
    ST_DROP_R,
    ST_LAND
  } state_e;

  localparam int SCREEN_W       = 160;
  localparam int SCREEN_H       = 120;
  localparam int FRAME_DIV_60HZ = 833334;

  // Bits needed to hold the values 0..n-1, never less than one.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Frame tick divider shared by the sprite movers: one-cycle tick every
// FRAME_DIV enabled clocks; clr takes priority and restarts the count.
module tick_gen
  import game_pkg::*;
#(
  parameter int FRAME_DIV = FRAME_DIV_60HZ
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = cnt_w(FRAME_DIV);

  logic [CW-1:0] cnt_q;

  assign tick = en && (cnt_q == CW'(FRAME_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/game_alien_mover.sv
// Serpentine alien motion: sweep right, drop, sweep left, drop, until the
// landing row; each drop shortens the move period down to a floor.
module game_alien_mover
  import game_pkg::*;
#(
  parameter int X_W         = 8,
  parameter int Y_W         = 7,
  parameter int X_MIN       = 18,
  parameter int X_MAX       = 26,
  parameter int Y_START     = 15,
  parameter int Y_LIMIT     = 112,
  parameter int X_STEP      = 1,
  parameter int DROP_STEP   = 4,
  parameter int FRAME_DIV   = FRAME_DIV_60HZ,
  parameter int INIT_PERIOD = 15,
  parameter int MIN_PERIOD  = 2,
  parameter int SPEEDUP     = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           go,
  input  logic           pause,
  input  logic           kill,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           alive,
  output logic           dir,
  output logic           moved,
  output logic           landed
);

  // Wide enough for INIT_PERIOD and for MIN_PERIOD + SPEEDUP in the clamp compare.
  localparam int PW = cnt_w(INIT_PERIOD + MIN_PERIOD + SPEEDUP + 1);

  if (Y_LIMIT > (2 ** Y_W) - 1 - DROP_STEP) begin : g_bad_y_limit
    $error("game_alien_mover: Y_LIMIT leaves no headroom for a drop");
  end
  if (MIN_PERIOD < 1 || INIT_PERIOD < 1) begin : g_bad_period
    $error("game_alien_mover: move periods must be at least 1");
  end
  if (X_MIN >= X_MAX) begin : g_bad_x_bounds
    $error("game_alien_mover: X_MIN must be left of X_MAX");
  end

  state_e         state_q;
  logic [X_W-1:0] x_q;
  logic [Y_W-1:0] y_q;
  logic           alive_q, dir_q, moved_q, landed_q;
  logic [PW-1:0]  step_q, period_q, period_d;

  logic           running, tick, move;
  logic [X_W:0]   x_ext, x_right;
  logic [Y_W:0]   y_drop;
  logic           hit_right, hit_left, lands;

  assign running = (state_q == ST_RIGHT) || (state_q == ST_LEFT);

  tick_gen #(.FRAME_DIV(FRAME_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .en    (running && !pause),
    .clr   (!running),
    .tick  (tick)
  );

  assign move = tick && (step_q == period_q - 1'b1);

  // Bounds are evaluated one bit wider so the step cannot wrap past zero or the top.
  assign x_ext     = {1'b0, x_q};
  assign x_right   = x_ext + (X_W+1)'(X_STEP);
  assign hit_right = x_right >= (X_W+1)'(X_MAX);
  assign hit_left  = x_ext <= (X_W+1)'(X_MIN + X_STEP);
  assign y_drop    = {1'b0, y_q} + (Y_W+1)'(DROP_STEP);
  assign lands     = y_drop >= (Y_W+1)'(Y_LIMIT);
  assign period_d  = (period_q <= PW'(MIN_PERIOD + SPEEDUP)) ? PW'(MIN_PERIOD)
                                                             : period_q - PW'(SPEEDUP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      x_q      <= X_W'(X_MIN);
      y_q      <= Y_W'(Y_START);
      alive_q  <= 1'b0;
      dir_q    <= 1'b0;
      moved_q  <= 1'b0;
      landed_q <= 1'b0;
      step_q   <= '0;
      period_q <= PW'(INIT_PERIOD);
    end else begin
      moved_q  <= 1'b0;
      landed_q <= 1'b0;
      if (kill && state_q != ST_IDLE) begin
        // Position is held so the draw engine can erase the sprite in place.
        state_q <= ST_IDLE;
        alive_q <= 1'b0;
        step_q  <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (go) begin
              state_q  <= ST_RIGHT;
              x_q      <= X_W'(X_MIN);
              y_q      <= Y_W'(Y_START);
              period_q <= PW'(INIT_PERIOD);
              alive_q  <= 1'b1;
              dir_q    <= 1'b0;
              step_q   <= '0;
            end
          end
          ST_RIGHT, ST_LEFT: begin
            if (move) begin
              step_q  <= '0;
              moved_q <= 1'b1;
              if (state_q == ST_RIGHT) begin
                if (hit_right) begin
                  x_q     <= X_W'(X_MAX);
                  state_q <= ST_DROP_L;
                end else begin
                  x_q <= x_q + X_W'(X_STEP);
                end
              end else begin
                if (hit_left) begin
                  x_q     <= X_W'(X_MIN);
                  state_q <= ST_DROP_R;
                end else begin
                  x_q <= x_q - X_W'(X_STEP);
                end
              end
            end else if (tick) begin
              step_q <= step_q + 1'b1;
            end
          end
          ST_DROP_L, ST_DROP_R: begin
            y_q      <= y_drop[Y_W-1:0];
            moved_q  <= 1'b1;
            period_q <= period_d;
            if (lands) begin
              state_q <= ST_LAND;
            end else if (state_q == ST_DROP_L) begin
              state_q <= ST_LEFT;
              dir_q   <= 1'b1;
            end else begin
              state_q <= ST_RIGHT;
              dir_q   <= 1'b0;
            end
          end
          ST_LAND: begin
            landed_q <= 1'b1;
            alive_q  <= 1'b0;
            state_q  <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign x      = x_q;
  assign y      = y_q;
  assign alive  = alive_q;
  assign dir    = dir_q;
  assign moved  = moved_q;
  assign landed = landed_q;

endmodule

// File: tb/tb_game_alien_mover.sv
// Bench for game_alien_mover: two instances (a long sweep with speed-up and a
// short one that lands) share stimulus and are checked every cycle against a model.
module tb_game_alien_mover;

  // Instance A: slow start with speed-up; instance B: starts near the landing row.
  localparam int A_FD = 2, A_INIT = 4, A_MIN = 2, A_SPD = 1, A_YS = 15;
  localparam int B_FD = 2, B_INIT = 1, B_MIN = 1, B_SPD = 1, B_YS = 104;

  typedef struct {
    int fd, init_p, min_p, spd, xmin, xmax, xstep, ystart, ylim, dstep;
  } cfg_t;

  typedef struct {
    int phase, x, y, dir, alive, moved, landed, cd, period;
  } mdl_t;

  localparam int PH_IDLE = 0, PH_RUN = 1, PH_DROP = 2, PH_LAND = 3;

  localparam cfg_t CA = '{fd: A_FD, init_p: A_INIT, min_p: A_MIN, spd: A_SPD,
                          xmin: 18, xmax: 26, xstep: 1, ystart: A_YS, ylim: 112, dstep: 4};
  localparam cfg_t CB = '{fd: B_FD, init_p: B_INIT, min_p: B_MIN, spd: B_SPD,
                          xmin: 18, xmax: 26, xstep: 1, ystart: B_YS, ylim: 112, dstep: 4};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic go = 1'b0, pause = 1'b0, kill = 1'b0;

  logic [7:0] a_x, b_x;
  logic [6:0] a_y, b_y;
  logic a_alive, a_dir, a_moved, a_landed;
  logic b_alive, b_dir, b_moved, b_landed;

  int n_cmp = 0;
  int n_bad = 0;

  mdl_t ma, mb;

  always #5 clk = ~clk;

  game_alien_mover #(
    .FRAME_DIV(A_FD), .INIT_PERIOD(A_INIT), .MIN_PERIOD(A_MIN), .SPEEDUP(A_SPD), .Y_START(A_YS)
  ) u_dut_a (
    .clk(clk), .reset(reset), .go(go), .pause(pause), .kill(kill),
    .x(a_x), .y(a_y), .alive(a_alive), .dir(a_dir), .moved(a_moved), .landed(a_landed)
  );

  game_alien_mover #(
    .FRAME_DIV(B_FD), .INIT_PERIOD(B_INIT), .MIN_PERIOD(B_MIN), .SPEEDUP(B_SPD), .Y_START(B_YS)
  ) u_dut_b (
    .clk(clk), .reset(reset), .go(go), .pause(pause), .kill(kill),
    .x(b_x), .y(b_y), .alive(b_alive), .dir(b_dir), .moved(b_moved), .landed(b_landed)
  );

  function automatic mdl_t mdl_reset(input cfg_t c);
    mdl_t m;
    m.phase = PH_IDLE; m.x = c.xmin; m.y = c.ystart; m.dir = 0; m.alive = 0;
    m.moved = 0; m.landed = 0; m.cd = 0; m.period = c.init_p;
    return m;
  endfunction

  // Motion as "clocks remaining until the next move" rather than tick/step counters.
  function automatic mdl_t mdl_step(input mdl_t m, input cfg_t c,
                                    input bit g, input bit p, input bit k);
    mdl_t n = m;
    n.moved = 0;
    n.landed = 0;
    if (m.phase == PH_IDLE) begin
      if (g) begin
        n.phase = PH_RUN; n.x = c.xmin; n.y = c.ystart; n.period = c.init_p;
        n.alive = 1; n.dir = 0; n.cd = c.init_p * c.fd;
      end
    end else if (k) begin
      n.phase = PH_IDLE;
      n.alive = 0;
    end else begin
      case (m.phase)
        PH_RUN: if (!p) begin
          n.cd = m.cd - 1;
          if (n.cd == 0) begin
            n.moved = 1;
            n.cd = m.period * c.fd;
            if (m.dir == 0) begin
              if (m.x + c.xstep >= c.xmax) begin n.x = c.xmax; n.phase = PH_DROP; end
              else n.x = m.x + c.xstep;
            end else begin
              if (m.x <= c.xmin + c.xstep) begin n.x = c.xmin; n.phase = PH_DROP; end
              else n.x = m.x - c.xstep;
            end
          end
        end
        PH_DROP: begin
          n.y = m.y + c.dstep;
          n.moved = 1;
          n.period = (m.period - c.spd < c.min_p) ? c.min_p : m.period - c.spd;
          if (n.y >= c.ylim) n.phase = PH_LAND;
          else begin
            n.phase = PH_RUN;
            n.dir = (m.dir == 0) ? 1 : 0;
            n.cd = n.period * c.fd;
          end
        end
        default: begin
          n.landed = 1;
          n.alive = 0;
          n.phase = PH_IDLE;
        end
      endcase
    end
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ma <= mdl_reset(CA);
      mb <= mdl_reset(CB);
    end else begin
      ma <= mdl_step(ma, CA, go, pause, kill);
      mb <= mdl_step(mb, CB, go, pause, kill);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      chk("A.x", int'(a_x), ma.x);           chk("A.y", int'(a_y), ma.y);
      chk("A.alive", int'(a_alive), ma.alive); chk("A.dir", int'(a_dir), ma.dir);
      chk("A.moved", int'(a_moved), ma.moved); chk("A.landed", int'(a_landed), ma.landed);
      chk("B.x", int'(b_x), mb.x);           chk("B.y", int'(b_y), mb.y);
      chk("B.alive", int'(b_alive), mb.alive); chk("B.dir", int'(b_dir), mb.dir);
      chk("B.moved", int'(b_moved), mb.moved); chk("B.landed", int'(b_landed), mb.landed);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    cyc(3);
    reset = 1'b0;
    cyc(1);
    chk("rst A.x", int'(a_x), 18);      chk("rst A.y", int'(a_y), 15);
    chk("rst A.alive", int'(a_alive), 0); chk("rst B.y", int'(b_y), 104);
    $display("reset released: A=(%0d,%0d) B=(%0d,%0d)", a_x, a_y, b_x, b_y);

    // First sweep; cycle numbers below count edges after the go edge.
    go = 1'b1; cyc(1); go = 1'b0;
    chk("go A.alive", int'(a_alive), 1);
    cyc(2);  chk("E2 B.x", int'(b_x), 19); chk("E2 A.x", int'(a_x), 18);
    cyc(6);  chk("E8 A.x", int'(a_x), 19); chk("E8 A.moved", int'(a_moved), 1);
    cyc(27); chk("E35 B.landed", int'(b_landed), 1); chk("E35 B.alive", int'(b_alive), 0);
             chk("E35 B.y", int'(b_y), 112); chk("E35 B.x", int'(b_x), 18);
    $display("landing: B=(%0d,%0d) landed=%0d", b_x, b_y, b_landed);
    cyc(1);  chk("E36 B.landed", int'(b_landed), 0);
    cyc(29); chk("E65 A.y", int'(a_y), 19); chk("E65 A.dir", int'(a_dir), 1);
             chk("E65 A.x", int'(a_x), 26);
    cyc(6);  chk("E71 A.x", int'(a_x), 25);

    // Pause for 50 clocks; the pending move slides by exactly 50 clocks.
    pause = 1'b1; cyc(50); pause = 1'b0;
    chk("pause A.x", int'(a_x), 25);
    $display("pause released: A=(%0d,%0d)", a_x, a_y);
    cyc(5); chk("E126 A.x", int'(a_x), 25);
    cyc(1); chk("E127 A.x", int'(a_x), 24);

    go = 1'b1; cyc(1); go = 1'b0;
    chk("go-busy A.x", int'(a_x), 24); chk("go-busy A.alive", int'(a_alive), 1);

    // Asynchronous reset between edges.
    #2 reset = 1'b1;
    #1;
    chk("areset A.x", int'(a_x), 18); chk("areset A.y", int'(a_y), 15);
    chk("areset A.alive", int'(a_alive), 0); chk("areset A.dir", int'(a_dir), 0);
    chk("areset B.y", int'(b_y), 104);
    $display("async reset: A=(%0d,%0d) alive=%0d", a_x, a_y, a_alive);
    cyc(1); reset = 1'b0;

    kill = 1'b1; cyc(1); kill = 1'b0;
    chk("idle-kill A.alive", int'(a_alive), 0);

    go = 1'b1; cyc(1); go = 1'b0;
    cyc(24); chk("kill-pre A.x", int'(a_x), 21);
    kill = 1'b1; cyc(1); kill = 1'b0;
    chk("kill A.alive", int'(a_alive), 0); chk("kill A.x", int'(a_x), 21);
    chk("kill A.landed", int'(a_landed), 0);
    cyc(3);  chk("kill-hold A.x", int'(a_x), 21);
    $display("kill: A=(%0d,%0d) alive=%0d", a_x, a_y, a_alive);

    // go with kill in IDLE starts the sweep.
    go = 1'b1; kill = 1'b1; cyc(1); go = 1'b0; kill = 1'b0;
    chk("restart A.alive", int'(a_alive), 1); chk("restart A.x", int'(a_x), 18);
    chk("restart A.y", int'(a_y), 15);
    cyc(65); chk("E65 A.y row1", int'(a_y), 19);
    cyc(49); chk("E114 A.y", int'(a_y), 23); chk("E114 A.dir", int'(a_dir), 0);
             chk("E114 A.x", int'(a_x), 18);
    cyc(4);  chk("E118 A.x", int'(a_x), 19);
    cyc(4);  chk("E122 A.x", int'(a_x), 20);
    cyc(24); chk("E146 A.x", int'(a_x), 26);
    cyc(1);  chk("E147 A.y", int'(a_y), 27); chk("E147 A.dir", int'(a_dir), 1);
    cyc(4);  chk("E151 A.x", int'(a_x), 25);
    $display("row 3: A=(%0d,%0d) dir=%0d", a_x, a_y, a_dir);
    cyc(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
